// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and registered ALU operand forward selects for a
// 5-stage pipeline, built on a shadow copy of the EX/MEM/WB destination info.

module hfu_fwd_sel #(
    parameter int RA_W = 5
) (
    input  logic            i_enter,
    input  logic            i_use,
    input  logic [RA_W-1:0] i_rs,
    input  logic            i_ex_wr,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_mem_wr,
    input  logic [RA_W-1:0] i_mem_rd,
    output logic [1:0]      o_sel
);
    // Youngest producer wins; x0 never matches because writers need rd != 0.
    always_comb begin
        o_sel = 2'b00;
        if (i_enter && i_use) begin
            if (i_ex_wr && (i_ex_rd == i_rs))
                o_sel = 2'b01;
            else if (i_mem_wr && (i_mem_rd == i_rs))
                o_sel = 2'b10;
        end
    end
endmodule

module hazard_forward_unit #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [RA_W-1:0]  i_id_rs1,
    input  logic [RA_W-1:0]  i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [RA_W-1:0]  i_id_rd,
    input  logic             i_id_regwrite,
    input  logic             i_id_memread,
    input  logic             i_id_isjump,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [1:0]       o_forward_a,
    output logic [1:0]       o_forward_b,
    output logic             o_fwd_isjump,
    output logic [CNT_W-1:0] o_stall_cnt
);
    localparam int NSRC = 2;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
        logic            isjump;
    } sh_t;

    sh_t r_sh_ex, r_sh_mem, r_sh_wb;
    sh_t w_sh_in;

    logic                       w_ex_wr, w_mem_wr;
    logic                       w_enter;
    logic [NSRC-1:0]            w_use;
    logic [NSRC-1:0][RA_W-1:0]  w_rs;
    logic [NSRC-1:0]            w_hit;
    logic [NSRC-1:0][1:0]       w_sel;
    logic [NSRC-1:0][1:0]       r_fwd;
    logic                       r_fwd_isjump;
    logic [CNT_W-1:0]           r_cnt;

    assign w_ex_wr  = r_sh_ex.valid  && r_sh_ex.regwrite  && (r_sh_ex.rd  != '0);
    assign w_mem_wr = r_sh_mem.valid && r_sh_mem.regwrite && (r_sh_mem.rd != '0);

    assign w_use = {i_id_use_rs2, i_id_use_rs1};
    assign w_rs  = {i_id_rs2, i_id_rs1};

    // FLUSH dominates: a squashed instruction can never cause a stall.
    assign o_stall = i_id_valid && !i_flush && w_ex_wr && r_sh_ex.memread && (|w_hit);
    assign w_enter = i_id_valid && !i_flush && !o_stall;

    always_comb begin
        w_sh_in          = '0;
        w_sh_in.valid    = w_enter;
        w_sh_in.rd       = i_id_rd;
        w_sh_in.regwrite = i_id_regwrite;
        w_sh_in.memread  = i_id_memread;
        w_sh_in.isjump   = i_id_isjump;
    end

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            assign w_hit[g] = w_use[g] && (w_rs[g] == r_sh_ex.rd);

            hfu_fwd_sel #(.RA_W(RA_W)) u_sel (
                .i_enter  (w_enter),
                .i_use    (w_use[g]),
                .i_rs     (w_rs[g]),
                .i_ex_wr  (w_ex_wr),
                .i_ex_rd  (r_sh_ex.rd),
                .i_mem_wr (w_mem_wr),
                .i_mem_rd (r_sh_mem.rd),
                .o_sel    (w_sel[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh_ex      <= '0;
            r_sh_mem     <= '0;
            r_sh_wb      <= '0;
            r_fwd        <= '0;
            r_fwd_isjump <= 1'b0;
        end else begin
            r_sh_wb      <= r_sh_mem;
            r_sh_mem     <= r_sh_ex;
            r_sh_ex      <= w_sh_in;
            r_fwd        <= w_sel;
            r_fwd_isjump <= r_sh_ex.valid && r_sh_ex.isjump;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (o_stall && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_forward_a  = r_fwd[0];
    assign o_forward_b  = r_fwd[1];
    assign o_fwd_isjump = r_fwd_isjump;
    assign o_stall_cnt  = r_cnt;

    // WB shadow is kept for completeness of the pipeline image; nothing reads it yet.
    logic w_wb_unused;
    assign w_wb_unused = ^r_sh_wb;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized and directed checks of hazard_forward_unit against an in-flight
// instruction history model.

module tb_hazard_forward_unit;
    localparam int RA_W  = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk, rst;
    logic             id_valid, use1, use2, rw, mr, jmp, flush;
    logic [RA_W-1:0]  rs1, rs2, rd;
    logic             stall, fj;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] cnt;

    hazard_forward_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_id_rd(rd), .i_id_regwrite(rw), .i_id_memread(mr), .i_id_isjump(jmp),
        .i_flush(flush), .o_stall(stall), .o_forward_a(fa), .o_forward_b(fb),
        .o_fwd_isjump(fj), .o_stall_cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw, mr, jmp;
    } rec_t;

    rec_t hist[$];   // hist[0] = instruction now in EX, hist[1] = in MEM
    int   m_cnt;
    int   checks, failures;
    bit   obs_stall;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit produces(rec_t e, bit [4:0] r);
        return e.v && e.rw && (e.rd != 0) && (e.rd == r);
    endfunction

    function automatic int exp_sel(bit enter, bit u, bit [4:0] r);
        if (!enter || !u) return 0;
        if (produces(hist[0], r)) return 1;
        if (produces(hist[1], r)) return 2;
        return 0;
    endfunction

    task automatic model_clear();
        rec_t b;
        b = '{v:0, rd:0, rw:0, mr:0, jmp:0};
        hist.delete();
        repeat (3) hist.push_back(b);
        m_cnt = 0;
    endtask

    task automatic step(input bit v, input bit [4:0] a, input bit ua, input bit [4:0] b,
                        input bit ub, input bit [4:0] d, input bit w, input bit m,
                        input bit j, input bit f);
        bit   es, enter;
        int   efa, efb, efj;
        rec_t r;
        @(negedge clk);
        id_valid = v; rs1 = a; use1 = ua; rs2 = b; use2 = ub;
        rd = d; rw = w; mr = m; jmp = j; flush = f;
        #1;
        es = v && !f && hist[0].mr &&
             ((ua && produces(hist[0], a)) || (ub && produces(hist[0], b)));
        obs_stall = stall;
        chk("stall", int'(stall), int'(es));
        enter = v && !f && !es;
        efa = exp_sel(enter, ua, a);
        efb = exp_sel(enter, ub, b);
        efj = int'(hist[0].v && hist[0].jmp);
        @(posedge clk);
        #1;
        if (es && m_cnt < CMAX) m_cnt++;
        chk("fwd_a", int'(fa), efa);
        chk("fwd_b", int'(fb), efb);
        chk("fwd_isjump", int'(fj), efj);
        chk("stall_cnt", int'(cnt), m_cnt);
        r = '{v:enter, rd:d, rw:w, mr:m, jmp:j};
        hist.push_front(r);
        void'(hist.pop_back());
    endtask

    task automatic nop(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        model_clear();
        rst = 1'b1;
        id_valid = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
        rd = 0; rw = 0; mr = 0; jmp = 0; flush = 0;
        #3;
        chk("rst_stall", int'(stall), 0);
        chk("rst_fwd_a", int'(fa), 0);
        chk("rst_fwd_b", int'(fb), 0);
        chk("rst_isjump", int'(fj), 0);
        chk("rst_cnt", int'(cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back ALU dependency on rs1
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
        step(1, 5, 1, 6, 1, 3, 1, 0, 0, 0);
        chk("b2b_a", int'(fa), 1);
        chk("b2b_b", int'(fb), 0);
        chk("b2b_nostall", int'(obs_stall), 0);
        nop(3);

        // distance-2, then two writers in flight
        step(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        step(1, 3, 1, 4, 1, 8, 1, 0, 0, 0);
        step(1, 1, 1, 7, 1, 10, 1, 0, 0, 0);
        chk("dist2_b", int'(fb), 2);
        step(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        step(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        step(1, 1, 1, 7, 1, 10, 1, 0, 0, 0);
        chk("young_b", int'(fb), 1);
        nop(3);

        // load-use
        step(1, 2, 1, 0, 0, 9, 1, 1, 0, 0);
        step(1, 9, 1, 3, 1, 11, 1, 0, 0, 0);
        chk("lu_stall", int'(obs_stall), 1);
        chk("lu_cnt", int'(cnt), 1);
        step(1, 9, 1, 3, 1, 11, 1, 0, 0, 0);
        chk("lu_nostall", int'(obs_stall), 0);
        chk("lu_fwd_a", int'(fa), 2);
        nop(3);

        // x0 writer and unused source
        step(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 4, 1, 0, 0, 0);
        chk("x0_a", int'(fa), 0);
        chk("x0_b", int'(fb), 0);
        step(1, 1, 1, 2, 1, 12, 1, 0, 0, 0);
        step(1, 3, 1, 12, 0, 4, 1, 0, 0, 0);
        chk("unused_b", int'(fb), 0);
        nop(3);

        // jump forwarding
        step(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        step(1, 1, 1, 2, 1, 6, 1, 0, 0, 0);
        chk("jal_a", int'(fa), 1);
        chk("jal_isjump", int'(fj), 1);
        nop(3);

        // flush beats load-use stall
        step(1, 2, 1, 0, 0, 9, 1, 1, 0, 0);
        step(1, 9, 1, 3, 1, 11, 1, 0, 0, 1);
        chk("flush_nostall", int'(obs_stall), 0);
        chk("flush_cnt", int'(cnt), 1);
        nop(2);

        // asynchronous reset during a stall
        step(1, 2, 1, 0, 0, 9, 1, 1, 0, 0);
        @(negedge clk);
        id_valid = 1; rs1 = 9; use1 = 1; rs2 = 3; use2 = 1; rd = 11; rw = 1;
        mr = 0; jmp = 0; flush = 0;
        #1;
        chk("pre_rst_stall", int'(stall), 1);
        rst = 1'b1;
        #1;
        chk("arst_stall", int'(stall), 0);
        chk("arst_cnt", int'(cnt), 0);
        chk("arst_fwd_a", int'(fa), 0);
        chk("arst_isjump", int'(fj), 0);
        #1;
        rst = 1'b0;
        model_clear();
        step(1, 9, 1, 3, 1, 11, 1, 0, 0, 0);
        nop(3);

        // counter saturation
        for (int i = 0; i < CMAX + 40; i++) begin
            step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
            step(1, 9, 1, 0, 0, 11, 1, 0, 0, 0);
        end
        chk("sat_cnt", int'(cnt), CMAX);
        nop(3);

        // random traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
